seq_generator: RTL

- Transmit side of the 102210 digit-sequence link: emits the 4-bit digit stream 1,0,2,2,1,0 on O, one digit per CLK, for the sequence detector to consume.
- Started by a START pulse; supports N back-to-back repetitions with a programmable idle gap between them.
- Reports BUSY and a one-cycle DONE; used as a stimulus source and as the link transmitter in the top level.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/seq_generator.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// Shared constants and state encoding for the 102210 digit-sequence link.
// Used by the generator, the detector and the top-level bench.
package seq_pkg;

  localparam logic [3:0] DIG_1    = 4'd1;
  localparam logic [3:0] DIG_0    = 4'd0;
  localparam logic [3:0] DIG_2    = 4'd2;
  localparam logic [3:0] IDLE_VAL = 4'd15;

  localparam int unsigned SEQ_LEN  = 6;
  localparam logic [2:0]  OVL_IDX  = 3'd2;
  localparam logic [2:0]  LAST_IDX = 3'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2,
    StFin  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_generator.sv
// Transmitter for the 102210 digit stream: START-triggered burst of REPEAT+1 sequences,
// GAP idle cycles between them. Define SEQGEN_OVERLAP_EN to shorten gapless repeats to D2..D5.
module seq_generator
  import seq_pkg::*;
#(
  parameter logic [3:0] D0       = DIG_1,
  parameter logic [3:0] D1       = DIG_0,
  parameter logic [3:0] D2       = DIG_2,
  parameter logic [3:0] D3       = DIG_2,
  parameter logic [3:0] D4       = DIG_1,
  parameter logic [3:0] D5       = DIG_0,
  parameter logic [3:0] IDLE_VAL = seq_pkg::IDLE_VAL
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [3:0] REPEAT,
  input  logic [3:0] GAP,
  output logic [3:0] O,
  output logic       VALID,
  output logic       BUSY,
  output logic       DONE
);

`ifdef SEQGEN_OVERLAP_EN
  // Trailing 1,0 of the previous sequence doubles as the next prefix.
  localparam logic [2:0] RESTART_IDX = OVL_IDX;
`else
  localparam logic [2:0] RESTART_IDX = 3'd0;
`endif

  seq_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] rep_q, rep_d;
  logic [3:0] gap_len_q, gap_len_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [3:0] o_d;
  logic       valid_d, busy_d, done_d;

  function automatic logic [3:0] digit(input logic [2:0] i);
    case (i)
      3'd0:    digit = D0;
      3'd1:    digit = D1;
      3'd2:    digit = D2;
      3'd3:    digit = D3;
      3'd4:    digit = D4;
      3'd5:    digit = D5;
      default: digit = IDLE_VAL;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      idx_q     <= 3'd0;
      rep_q     <= 4'd0;
      gap_len_q <= 4'd0;
      gap_cnt_q <= 4'd0;
      O         <= IDLE_VAL;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      O         <= o_d;
      VALID     <= valid_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          rep_d     = REPEAT;
          gap_len_d = GAP;
          idx_d     = 3'd0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (idx_q == LAST_IDX) begin
          if (rep_q == 4'd0) begin
            idx_d   = 3'd0;
            state_d = StFin;
          end else begin
            rep_d = rep_q - 4'd1;
            if (gap_len_q != 4'd0) begin
              gap_cnt_d = gap_len_q;
              idx_d     = 3'd0;
              state_d   = StGap;
            end else begin
              idx_d = RESTART_IDX;
            end
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StGap: begin
        if (gap_cnt_q == 4'd1) begin
          gap_cnt_d = 4'd0;
          idx_d     = 3'd0;
          state_d   = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so that they land in flops.
  always_comb begin
    o_d     = IDLE_VAL;
    valid_d = 1'b0;
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StFin);
    if (state_d == StSend) begin
      o_d     = digit(idx_d);
      valid_d = 1'b1;
    end
  end

endmodule
